// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants for the fetch stage: RV32 control-flow opcodes and default geometry.
package ins_fetch_queue_pkg;

  localparam int QDEPTH_DEF    = 16;
  localparam int BHT_IDX_W_DEF = 8;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/ins_fetch_queue_predecode.sv
// Combinational pre-decode: next fetch PC and taken prediction, zero latency, no backpressure.
module ins_predecode
  import ins_fetch_queue_pkg::*;
(
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  input  logic        bht_get,
  output logic [31:0] next_pc,
  output logic        pred_jump
);

  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};

  // JALR targets depend on a register value, so it falls through and the ROB resolves it.
  always_comb begin
    next_pc   = pc + 32'd4;
    pred_jump = 1'b0;
    case (ins[6:0])
      OP_JAL: begin
        next_pc   = pc + j_imm;
        pred_jump = 1'b1;
      end
      OP_BRANCH: begin
        if (bht_get) begin
          next_pc   = pc + b_imm;
          pred_jump = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ins_fetch_queue.sv
// Fetch PC, BHT lookup and circular instruction FIFO; a hit enqueues and shows on out_* next cycle.
// Backpressure: fetch requests stop while the queue is full; rdy=0 freezes all state.
module ins_fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int          QDEPTH    = QDEPTH_DEF,
  parameter int          BHT_IDX_W = BHT_IDX_W_DEF,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear_flag,
  input  logic [31:0]          clear_pc,
  output logic                 icache_req,
  output logic [31:0]          icache_addr,
  input  logic                 icache_hit,
  input  logic [31:0]          icache_ins,
  output logic [BHT_IDX_W-1:0] bht_id,
  input  logic                 bht_get,
  output logic                 out_valid,
  output logic [31:0]          out_ins,
  output logic [31:0]          out_pc,
  output logic                 out_pred_jump,
  output logic [BHT_IDX_W-1:0] out_bht_id,
  input  logic                 deq_ready
);

  localparam int               PTR_W    = $clog2(QDEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(QDEPTH);

  logic [31:0]          pc_q, pc_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;

  logic [31:0]          ins_mem_q  [QDEPTH];
  logic [31:0]          pc_mem_q   [QDEPTH];
  logic                 pj_mem_q   [QDEPTH];
  logic [BHT_IDX_W-1:0] id_mem_q   [QDEPTH];

  logic [31:0]          pred_next_pc;
  logic                 pred_jump;
  logic                 enq;
  logic                 deq;

  ins_predecode u_predecode (
    .ins       (icache_ins),
    .pc        (pc_q),
    .bht_get   (bht_get),
    .next_pc   (pred_next_pc),
    .pred_jump (pred_jump)
  );

  assign icache_req    = (count_q != FULL_CNT);
  assign icache_addr   = pc_q;
  assign bht_id        = pc_q[BHT_IDX_W+1:2];
  assign out_valid     = (count_q != '0);
  assign out_ins       = ins_mem_q[head_q];
  assign out_pc        = pc_mem_q[head_q];
  assign out_pred_jump = pj_mem_q[head_q];
  assign out_bht_id    = id_mem_q[head_q];

  // A flush discards any transfer offered in the same cycle.
  assign enq = icache_req & icache_hit & ~clear_flag;
  assign deq = out_valid & deq_ready & ~clear_flag;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_flag) begin
      pc_d    = clear_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        pc_d   = pred_next_pc;
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && enq) begin
      ins_mem_q[tail_q] <= icache_ins;
      pc_mem_q[tail_q]  <= pc_q;
      pj_mem_q[tail_q]  <= pred_jump;
      id_mem_q[tail_q]  <= bht_id;
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed plus randomized bench for ins_fetch_queue against a queue-based reference model.
module tb_ins_fetch_queue;

  localparam int QD = 16;
  localparam logic [31:0] ADDI = 32'h00100093;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_flag, icache_hit, bht_get, deq_ready;
  logic [31:0] clear_pc, icache_ins;
  logic        icache_req, out_valid, out_pred_jump;
  logic [31:0] icache_addr, out_ins, out_pc;
  logic [7:0]  bht_id, out_bht_id;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pj;
    logic [7:0]  id;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ins_fetch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag(clear_flag), .clear_pc(clear_pc),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_hit(icache_hit),
    .icache_ins(icache_ins), .bht_id(bht_id), .bht_get(bht_get), .out_valid(out_valid),
    .out_ins(out_ins), .out_pc(out_pc), .out_pred_jump(out_pred_jump),
    .out_bht_id(out_bht_id), .deq_ready(deq_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  task automatic check_state();
    chk("icache_addr", icache_addr, mpc);
    chk("icache_req", 32'(icache_req), 32'(mq.size() != QD));
    chk("bht_id", 32'(bht_id), {24'h0, mpc[9:2]});
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_ins", out_ins, mq[0].ins);
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pred_jump", 32'(out_pred_jump), 32'(mq[0].pj));
      chk("out_bht_id", 32'(out_bht_id), 32'(mq[0].id));
    end
  endtask

  // Drive one cycle from a negedge, advance the model, then check at the following negedge.
  task automatic step(input logic r, input logic rd, input logic cf, input logic [31:0] cp,
                      input logic hit, input logic [31:0] ins, input logic bg, input logic dq);
    ent_t        e;
    logic        do_enq, do_deq;
    logic [31:0] npc;
    rst = r; rdy = rd; clear_flag = cf; clear_pc = cp;
    icache_hit = hit; icache_ins = ins; bht_get = bg; deq_ready = dq;
    if (r) begin
      mq.delete();
      mpc = 32'h0;
    end else if (rd) begin
      if (cf) begin
        mq.delete();
        mpc = cp;
      end else begin
        do_deq = (mq.size() != 0) && dq;
        do_enq = (mq.size() != QD) && hit;
        npc = mpc + 32'd4;
        e.ins = ins; e.pc = mpc; e.pj = 1'b0; e.id = mpc[9:2];
        if (ins[6:0] == 7'h6F) begin
          npc = mpc + imm_j(ins);
          e.pj = 1'b1;
        end else if (ins[6:0] == 7'h63 && bg) begin
          npc = mpc + imm_b(ins);
          e.pj = 1'b1;
        end
        if (do_deq) void'(mq.pop_front());
        if (do_enq) begin
          mq.push_back(e);
          mpc = npc;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic hit(input logic [31:0] ins, input logic bg, input logic dq);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins, bg, dq);
  endtask

  task automatic clr(input logic [31:0] pc);
    step(1'b0, 1'b1, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       w[6:0] = 7'h6F;
      1:       w[6:0] = 7'h63;
      2:       w[6:0] = 7'h67;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; clear_flag = 1'b0; clear_pc = 32'h0;
    icache_hit = 1'b0; icache_ins = 32'h0; bht_get = 1'b0; deq_ready = 1'b0;
    mpc = 32'h0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_addr", icache_addr, 32'h0);
    chk("rst_req", 32'(icache_req), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);

    // Sequential fetch of plain ALU words
    hit(ADDI, 1'b0, 1'b0);
    chk("t1_addr4", icache_addr, 32'h4);
    chk("t1_outpc", out_pc, 32'h0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    hit(ADDI, 1'b0, 1'b0);
    chk("t1_addr8", icache_addr, 32'h8);
    hit(ADDI, 1'b0, 1'b0);
    chk("t1_addr12", icache_addr, 32'hC);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("t1_drained", 32'(out_valid), 32'h0);

    // Conditional branch, taken and not taken
    clr(32'h40);
    hit(32'hFE0008E3, 1'b1, 1'b0);
    chk("t2_taken_addr", icache_addr, 32'h30);
    chk("t2_pj", 32'(out_pred_jump), 32'h1);
    chk("t2_id", 32'(out_bht_id), 32'h10);
    clr(32'h40);
    hit(32'hFE0008E3, 1'b0, 1'b0);
    chk("t2_nt_addr", icache_addr, 32'h44);
    chk("t2_nt_pj", 32'(out_pred_jump), 32'h0);

    // JAL and JALR
    clr(32'h100);
    hit(32'h0010006F, 1'b0, 1'b0);
    chk("t3_jal_addr", icache_addr, 32'h900);
    chk("t3_jal_pj", 32'(out_pred_jump), 32'h1);
    clr(32'h100);
    hit(32'h00008067, 1'b1, 1'b0);
    chk("t3_jalr_addr", icache_addr, 32'h104);
    chk("t3_jalr_pj", 32'(out_pred_jump), 32'h0);

    // Fill to full, then one dequeue
    clr(32'h0);
    for (int i = 0; i < 18; i++) hit(ADDI, 1'b0, 1'b0);
    chk("t4_full_req", 32'(icache_req), 32'h0);
    chk("t4_frozen_pc", icache_addr, 32'h40);
    hit(ADDI, 1'b0, 1'b1);
    chk("t4_reopen_req", 32'(icache_req), 32'h1);
    chk("t4_no_enq_pc", icache_addr, 32'h40);
    hit(ADDI, 1'b0, 1'b0);

    // Flush beats a same-cycle hit and dequeue
    clr(32'h0);
    for (int i = 0; i < 5; i++) hit(ADDI, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h2000, 1'b1, ADDI, 1'b0, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_addr", icache_addr, 32'h2000);

    // Global stall
    clr(32'h300);
    hit(ADDI, 1'b0, 1'b0);
    hit(ADDI, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ADDI, 1'b0, 1'b1);
    chk("t6_stall_addr", icache_addr, 32'h308);
    chk("t6_stall_head", out_pc, 32'h300);

    // Pointer wrap with paired enqueue/dequeue
    clr(32'h0);
    hit(ADDI, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) hit({$urandom_range(0, 32'h1FFFFFF), 7'h13}, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
           $urandom, $urandom_range(0, 3) != 0, rand_ins(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
